pulse_detect: RTL
=================

PULSE_DETECT -- requirements
Module: pulse_detect

Interface
REQ-001 SHALL have parameter NSAMP, default 16, samples per AXIS beat.
REQ-002 SHALL have parameter SAMPLE_W, default 16, signed sample width.
REQ-003 SHALL have parameter HOLDOFF, default 4, beats ignored after a record in continuous mode.
REQ-004 SHALL have port clk  in  1  single clock from RFSoC ADC module.
REQ-005 SHALL have port rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port s_axis_tdata  in  256  ADC beat; sample k at bits [255-16k -: 16], k=0 earliest.
REQ-007 SHALL have ports s_axis_tvalid in 1 and s_axis_tready out 1 (beat accepted when both high).
REQ-008 SHALL have port threshold  in  16  signed detection level.
REQ-009 SHALL have port timeout  in  16  coarse-beat limit; 0 disables timeout.
REQ-010 SHALL have port arm  in  1  one-cycle strobe starting a measurement window.
REQ-011 SHALL have ports fifo_full in 1, fifo_write out 1, fifo_data out 32 (result FIFO writer).
REQ-012 SHALL have port state_out  out  8  current state encoding.

Function
REQ-013 SHALL hold s_axis_tready at 1 at all times outside reset; beats are never back-pressured.
REQ-014 SHALL register each accepted beat and its valid flag in one input stage before evaluation.
REQ-015 SHALL implement states IDLE=0, ARMED=1, WRITE=2, HOLDOFF=3.
REQ-016 IDLE: on arm, coarse<=0, go ARMED; registered beats ignored.
REQ-017 ARMED: per registered valid beat, hit = any sample >= threshold (signed); fine = lowest k with hit.
REQ-018 ARMED hit: record {8'h01, coarse, fine}; coarse = valid beats evaluated since arm, first beat = 0.
REQ-019 ARMED no hit: if timeout!=0 and coarse==timeout-1, record {8'h02, timeout, 8'h00}; else coarse+1, saturating at 16'hFFFF.
REQ-020 Registered beats with valid=0 SHALL NOT advance coarse or trigger detection.
REQ-021 On a record with fifo_full=0, fifo_write SHALL pulse high the next cycle with fifo_data; latency beat-presented to fifo_write = 2 cycles.
REQ-022 On a record with fifo_full=1, SHALL enter WRITE holding the record; in WRITE, first cycle with fifo_full=0 pulses fifo_write next cycle.
REQ-023 fifo_write SHALL be high for exactly one cycle per record; fifo_data SHALL be stable while high.
REQ-024 After a write, SHALL return to IDLE (see REQ-030 for continuous mode).
REQ-025 arm in ARMED SHALL restart the window (coarse<=0) and take priority over a simultaneous hit or timeout on that cycle.
REQ-026 arm in WRITE or HOLDOFF SHALL be ignored.
REQ-027 Unknown state encodings SHALL force IDLE.

Reset
REQ-028 On rst: state=IDLE, coarse=0, fifo_write=0, fifo_data=0, input stage valid=0, s_axis_tready=0 during the reset cycle.
REQ-029 rst mid-window or in WRITE SHALL discard any pending record without writing it.

Configuration
REQ-030 With PULSE_DET_CONTINUOUS_EN defined: after a hit write, SHALL enter HOLDOFF, skip HOLDOFF valid beats (coarse still advancing), then return to ARMED without reset of coarse; timeout still ends the window to IDLE.
REQ-031 Without PULSE_DET_CONTINUOUS_EN: one record per arm, HOLDOFF state unreachable, HOLDOFF parameter unused.

Structure
REQ-032 Package pulse_det_pkg SHALL hold state encodings, record tags (HIT=8'h01, TIMEOUT=8'h02) and sample-width constants.
REQ-033 SHALL use one combinational sub-module sample_thresh_encoder: 256-bit beat + threshold -> hit, fine.

Verification
REQ-034 arm, 3 zero beats, then beat with sample 5 = 16'h4000, threshold=16'h1000 -> one write 32'h01_0003_05, 2 cycles after beat.
REQ-035 threshold=16'h0100, samples 2 and 9 exceed -> fine=8'h02; negative sample 16'h8000 never hits.
REQ-036 timeout=4, no hits -> write 32'h02_0004_00 after 4th valid beat; state IDLE.
REQ-037 fifo_full=1 for 10 cycles at hit -> no write while full, single write 1 cycle after release, data unchanged.
REQ-038 arm on same cycle as a hit beat in ARMED -> no write; coarse restarts at 0; rst during WRITE -> no write.
REQ-039 Continuous build, HOLDOFF=4, hits at beats 1, 3, 8 -> records coarse 1 and 8 only.

Source files
------------

// File: rtl/pulse_det_pkg.sv
// -----------------------------------------------------------------------------
// pulse_det_pkg
// Shared definitions for the pulse detector: FSM state encodings, result
// record tags, sample/record widths and small helpers that build records and
// advance the coarse beat counter.
// No ports (package).
// -----------------------------------------------------------------------------
package pulse_det_pkg;

    localparam int DEF_NSAMP    = 16;
    localparam int DEF_SAMPLE_W = 16;
    localparam int COARSE_W     = 16;
    localparam int FINE_W       = 8;
    localparam int TAG_W        = 8;
    localparam int RECORD_W     = TAG_W + COARSE_W + FINE_W;

    localparam logic [TAG_W-1:0] TAG_HIT     = 8'h01;
    localparam logic [TAG_W-1:0] TAG_TIMEOUT = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_WRITE   = 2'd2,
        ST_HOLDOFF = 2'd3
    } pd_state_t;

    // A result record is {tag, coarse beat index, fine sample index}.
    function automatic logic [RECORD_W-1:0] make_record(
        input logic [TAG_W-1:0]    tag,
        input logic [COARSE_W-1:0] coarse,
        input logic [FINE_W-1:0]   fine
    );
        return {tag, coarse, fine};
    endfunction

    // The coarse counter sticks at all-ones instead of wrapping, so a very
    // long window never reports a small, misleading beat index.
    function automatic logic [COARSE_W-1:0] sat_inc(input logic [COARSE_W-1:0] value);
        return (value == {COARSE_W{1'b1}}) ? value : value + {{(COARSE_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/sample_thresh_encoder.sv
// -----------------------------------------------------------------------------
// sample_thresh_encoder
// Purely combinational: compares every signed sample of one ADC beat against a
// signed threshold and reports whether any sample reached it, plus the index of
// the earliest such sample.
// Ports:
//   beat      in  NSAMP*SAMPLE_W  packed beat, sample k at the k-th field from
//                                 the MSB end (k = 0 is the earliest sample)
//   threshold in  SAMPLE_W        signed detection level
//   hit       out 1               some sample >= threshold
//   fine      out FINE_W          lowest k that hit (0 when no hit)
// -----------------------------------------------------------------------------
module sample_thresh_encoder
    import pulse_det_pkg::*;
#(
    parameter int NSAMP    = DEF_NSAMP,
    parameter int SAMPLE_W = DEF_SAMPLE_W
) (
    input  logic [NSAMP*SAMPLE_W-1:0] beat,
    input  logic [SAMPLE_W-1:0]       threshold,
    output logic                      hit,
    output logic [FINE_W-1:0]         fine
);

    // Scan from the latest sample down to the earliest so that the last
    // assignment to fine, i.e. the one that sticks, is the lowest hitting index.
    always_comb begin
        hit  = 1'b0;
        fine = '0;
        for (int k = NSAMP - 1; k >= 0; k--) begin
            if ($signed(beat[NSAMP*SAMPLE_W-1-SAMPLE_W*k -: SAMPLE_W]) >= $signed(threshold)) begin
                hit  = 1'b1;
                fine = FINE_W'(k);
            end
        end
    end

endmodule

// File: rtl/pulse_detect.sv
// -----------------------------------------------------------------------------
// pulse_detect
// Watches an AXI-Stream of ADC beats for the first sample that reaches a
// signed threshold after an arm strobe, and writes a 32-bit result record
// ({tag, coarse beat index, fine sample index}) into a downstream FIFO. A
// window that sees no hit within 'timeout' valid beats writes a timeout record.
//
// Build option: define PULSE_DET_CONTINUOUS_EN to keep the window open after a
// hit; the detector then skips HOLDOFF valid beats and re-arms by itself, with
// the coarse counter still running. Without it, one record is written per arm
// and the HOLDOFF state is never entered.
//
// Ports:
//   clk            in  1        ADC clock
//   rst            in  1        synchronous, active-high reset
//   s_axis_tdata   in  256      ADC beat (NSAMP samples of SAMPLE_W bits)
//   s_axis_tvalid  in  1        beat valid
//   s_axis_tready  out 1        always 1 outside reset
//   threshold      in  16       signed detection level
//   timeout        in  16       window length in valid beats, 0 = no limit
//   arm            in  1        one-cycle strobe opening/restarting a window
//   fifo_full      in  1        result FIFO cannot accept a write
//   fifo_write     out 1        one-cycle write strobe
//   fifo_data      out 32       result record
//   state_out      out 8        current state encoding
// -----------------------------------------------------------------------------
module pulse_detect
    import pulse_det_pkg::*;
#(
    parameter int NSAMP    = DEF_NSAMP,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int HOLDOFF  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NSAMP*SAMPLE_W-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [SAMPLE_W-1:0]       threshold,
    input  logic [COARSE_W-1:0]       timeout,
    input  logic                      arm,
    input  logic                      fifo_full,
    output logic                      fifo_write,
    output logic [RECORD_W-1:0]       fifo_data,
    output logic [7:0]                state_out
);

    // Where the FSM goes once a hit record has actually been written.
`ifdef PULSE_DET_CONTINUOUS_EN
    localparam pd_state_t AFTER_HIT = ST_HOLDOFF;
`else
    localparam pd_state_t AFTER_HIT = ST_IDLE;
`endif

    localparam logic [15:0] HOLD_LAST = 16'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    logic [NSAMP*SAMPLE_W-1:0] beat_q;
    logic                      beat_valid_q;
    pd_state_t                 state;
    logic [COARSE_W-1:0]       coarse;
    logic [RECORD_W-1:0]       pending;
    logic [15:0]               hold_cnt;
    logic                      hit;
    logic [FINE_W-1:0]         fine;
    logic                      timeout_due;
    logic [RECORD_W-1:0]       hit_record;
    logic [RECORD_W-1:0]       timeout_record;
    logic                      pending_is_hit;

    // The stream is never back-pressured; ready only drops while reset is held.
    assign s_axis_tready = ~rst;
    assign state_out     = {6'b000000, state};

    // Input stage: every accepted beat is registered together with its valid
    // flag, and the detector always evaluates this registered copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q       <= '0;
            beat_valid_q <= 1'b0;
        end else begin
            beat_valid_q <= s_axis_tvalid & s_axis_tready;
            if (s_axis_tvalid & s_axis_tready) begin
                beat_q <= s_axis_tdata;
            end
        end
    end

    sample_thresh_encoder #(
        .NSAMP    (NSAMP),
        .SAMPLE_W (SAMPLE_W)
    ) u_encoder (
        .beat      (beat_q),
        .threshold (threshold),
        .hit       (hit),
        .fine      (fine)
    );

    // Candidate records and the timeout condition for the beat being evaluated.
    // The timeout fires on the last allowed beat, i.e. when the zero-based
    // coarse index reaches timeout-1.
    always_comb begin
        timeout_due    = (timeout != '0) && (coarse == timeout - 16'd1);
        hit_record     = make_record(TAG_HIT, coarse, fine);
        timeout_record = make_record(TAG_TIMEOUT, timeout, 8'h00);
        pending_is_hit = (pending[RECORD_W-1 -: TAG_W] == TAG_HIT);
    end

    // Main FSM. A record is written straight away when the FIFO has room;
    // otherwise it is parked in 'pending' and the WRITE state waits for space.
    // The coarse counter also steps on a hit beat so that, when the window
    // stays open, it still counts every valid beat since arm.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            coarse     <= '0;
            pending    <= '0;
            hold_cnt   <= '0;
            fifo_write <= 1'b0;
            fifo_data  <= '0;
        end else begin
            fifo_write <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        coarse <= '0;
                        state  <= ST_ARMED;
                    end
                end

                ST_ARMED: begin
                    if (arm) begin
                        coarse <= '0;
                    end else if (beat_valid_q) begin
                        if (hit) begin
                            coarse <= sat_inc(coarse);
                            if (!fifo_full) begin
                                fifo_write <= 1'b1;
                                fifo_data  <= hit_record;
                                hold_cnt   <= '0;
                                state      <= AFTER_HIT;
                            end else begin
                                pending <= hit_record;
                                state   <= ST_WRITE;
                            end
                        end else if (timeout_due) begin
                            if (!fifo_full) begin
                                fifo_write <= 1'b1;
                                fifo_data  <= timeout_record;
                                state      <= ST_IDLE;
                            end else begin
                                pending <= timeout_record;
                                state   <= ST_WRITE;
                            end
                        end else begin
                            coarse <= sat_inc(coarse);
                        end
                    end
                end

                ST_WRITE: begin
                    if (!fifo_full) begin
                        fifo_write <= 1'b1;
                        fifo_data  <= pending;
                        hold_cnt   <= '0;
                        state      <= pending_is_hit ? AFTER_HIT : ST_IDLE;
                    end
                end

                ST_HOLDOFF: begin
                    if (beat_valid_q) begin
                        coarse <= sat_inc(coarse);
                        if (hold_cnt == HOLD_LAST) begin
                            state <= ST_ARMED;
                        end else begin
                            hold_cnt <= hold_cnt + 16'd1;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
